// File: rtl/matrix_loader.sv
// Collects a DEPTH x DEPTH matrix streamed row-major, parallel-loads each completed
// row into transpose FIFO r, then issues a diagonally skewed shift sequence to drain them.
module matrix_loader #(
  parameter int DEPTH = 8,
  parameter int BITS  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [BITS-1:0]  in_data,
  output logic             in_ready,
  output logic [BITS-1:0]  d [DEPTH-1:0],
  output logic [DEPTH-1:0] wr_en,
  output logic [DEPTH-1:0] shift_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(DEPTH);
  localparam int SW = $clog2(2 * DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, LAST, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   row, col;
  logic [SW-1:0]   s;
  logic [BITS-1:0] row_buf [DEPTH-1:0];
  logic            xfer, row_end, mat_end, shift_last;

  assign in_ready   = (state == FILL);
  assign busy       = (state != IDLE);
  assign xfer       = in_valid && (state == FILL);
  assign row_end    = xfer && (col == CW'(DEPTH - 1));
  assign mat_end    = row_end && (row == CW'(DEPTH - 1));
  assign shift_last = (state == SHIFT) && (s == SW'(2 * DEPTH - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (mat_end) state_nxt = LAST;
      LAST:    state_nxt = SHIFT;
      SHIFT:   if (shift_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
      s   <= '0;
    end else begin
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
      end else if (xfer) begin
        if (row_end) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (state == LAST)       s <= '0;
      else if (state == SHIFT) s <= s + 1'b1;
    end
  end

  // The last word of a row bypasses the buffer so d shows the full row in the strobe cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < DEPTH; c++) begin
        row_buf[c] <= '0;
        d[c]       <= '0;
      end
    end else begin
      if (xfer) row_buf[col] <= in_data;
      if (row_end) begin
        for (int c = 0; c < DEPTH; c++)
          d[c] <= (c == DEPTH - 1) ? in_data : row_buf[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en <= '0;
      done  <= 1'b0;
    end else begin
      wr_en <= row_end ? (DEPTH'(1) << row) : '0;
      done  <= shift_last;
    end
  end

  // FIFO r shifts for DEPTH cycles starting at s = r, giving the diagonal skew.
  always_comb begin
    shift_en = '0;
    if (state == SHIFT) begin
      for (int r = 0; r < DEPTH; r++)
        shift_en[r] = (int'(s) >= r) && (int'(s) <= r + DEPTH - 1);
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader at DEPTH=8, BITS=64.
module tb_matrix_loader;

  localparam int DEPTH = 8;
  localparam int BITS  = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic [BITS-1:0]  in_data;
  logic             in_ready;
  logic [BITS-1:0]  d [DEPTH-1:0];
  logic [DEPTH-1:0] wr_en;
  logic [DEPTH-1:0] shift_en;
  logic             busy;
  logic             done;

  int compared   = 0;
  int mismatched = 0;

  matrix_loader #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .d        (d),
    .wr_en    (wr_en),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_d_zero(input string tag);
    for (int c = 0; c < DEPTH; c++) check(tag, d[c], '0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_ready", 64'(in_ready), 64'd1);
  endtask

  // Streams 64 words; checks the row strobe and d after each row's last word.
  task automatic load(input logic [BITS-1:0] base, input bit ones, input bit bp, input int ign_k);
    logic [BITS-1:0] exp;
    for (int k = 0; k < DEPTH * DEPTH; k++) begin
      in_valid = 1'b1;
      in_data  = ones ? '1 : base + BITS'(k);
      if (k == ign_k) start = 1'b1;
      tick();
      start = 1'b0;
      if (k % DEPTH == DEPTH - 1) begin
        check("row_wr_en", 64'(wr_en), 64'(8'(1) << (k / DEPTH)));
        for (int c = 0; c < DEPTH; c++) begin
          exp = ones ? '1 : base + BITS'((k / DEPTH) * DEPTH + c);
          check("row_d", d[c], exp);
        end
      end else begin
        check("no_wr_en", 64'(wr_en), 64'd0);
      end
      if (k == DEPTH * DEPTH - 1) begin
        check("last_ready", 64'(in_ready), 64'd0);
        check("last_busy", 64'(busy), 64'd1);
      end else if (bp) begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        tick();
        check("bp_wr_en", 64'(wr_en), 64'd0);
        check("bp_ready", 64'(in_ready), 64'd1);
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [DEPTH-1:0] diag(input int s);
    logic [DEPTH-1:0] m = '0;
    for (int r = 0; r < DEPTH; r++) m[r] = (r <= s) && (s <= r + DEPTH - 1);
    return m;
  endfunction

  task automatic drain(input int ign_s, input bit b2b);
    for (int s = 0; s < 2 * DEPTH - 1; s++) begin
      tick();
      start = 1'b0;
      check("shift_en", 64'(shift_en), 64'(diag(s)));
      check("shift_wr_en", 64'(wr_en), 64'd0);
      check("shift_done", 64'(done), 64'd0);
      if (s == ign_s) start = 1'b1;
    end
    tick();
    start = 1'b0;
    check("done_pulse", 64'(done), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("done_shift_en", 64'(shift_en), 64'd0);
    if (b2b) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check("b2b_busy", 64'(busy), 64'd1);
      check("b2b_ready", 64'(in_ready), 64'd1);
      check("b2b_done_clr", 64'(done), 64'd0);
    end else begin
      tick();
      check("done_once", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_shift_en", 64'(shift_en), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_d_zero("rst_d");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_no_start", 64'(busy), 64'd0);

    // Nominal matrix
    do_start();
    load('0, 1'b0, 1'b0, -1);
    drain(-1, 1'b0);

    // Backpressure: alternating in_valid
    do_start();
    load('0, 1'b0, 1'b1, -1);
    drain(-1, 1'b0);

    // start ignored during FILL and SHIFT
    do_start();
    load('0, 1'b0, 1'b0, 20);
    drain(3, 1'b0);

    // Back-to-back matrices
    do_start();
    load('0, 1'b0, 1'b0, -1);
    drain(-1, 1'b1);
    load(64'd100, 1'b0, 1'b0, -1);
    drain(-1, 1'b0);

    // Reset during SHIFT cycle 5
    do_start();
    load('0, 1'b0, 1'b0, -1);
    for (int s = 0; s <= 5; s++) begin
      tick();
      check("pre_rst_shift", 64'(shift_en), 64'(diag(s)));
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_shift_en", 64'(shift_en), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check_d_zero("mid_rst_d");
    tick();
    tick();
    check("rst_hold_done", 64'(done), 64'd0);
    check("rst_hold_wr_en", 64'(wr_en), 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_done", 64'(done), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    do_start();
    load('0, 1'b0, 1'b0, -1);
    drain(-1, 1'b0);

    // All-ones words
    do_start();
    load('0, 1'b1, 1'b0, -1);
    drain(-1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
